// File: rtl/ads_drv_pkg.sv
// ads_drv_pkg: shared FSM state encoding and default configuration words
// for the ADS8528 parallel-bus driver.
package ads_drv_pkg;
    typedef enum logic [2:0] {
        S_ARST, S_CFG, S_IDLE, S_CONV, S_BUSY_HI, S_BUSY_LO, S_RD_L, S_RD_H
    } state_t;
    localparam logic [15:0] CFG_HI_DEF = 16'h1500;
    localparam logic [15:0] CFG_LO_DEF = 16'h0000;
endpackage

// File: rtl/ads_busy_sync.sv
// ads_busy_sync: 2-flop synchronizer for the ADC BUSY pin plus a wait-time
// watchdog that flags when BUSY has not reached the awaited level in time.
module ads_busy_sync #(
    parameter int BUSY_TIMEOUT = 1024
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_busy,
    input  logic i_wait,
    input  logic i_target,
    output logic o_busy_s,
    output logic o_timeout
);
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    logic          r_meta;
    logic          r_sync;
    logic [TW-1:0] r_cnt;
    logic          w_pending;

    assign w_pending = i_wait && (r_sync != i_target);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_meta <= i_busy;
            r_sync <= r_meta;
            r_cnt  <= w_pending ? r_cnt + 1'b1 : '0;
        end
    end

    // An edge arriving in the final cycle clears w_pending, so the edge wins.
    assign o_busy_s  = r_sync;
    assign o_timeout = w_pending && (r_cnt == TW'(BUSY_TIMEOUT - 1));
endmodule

// File: rtl/ads_par_adc_driver.sv
// ads_par_adc_driver: ADS8528 parallel-bus driver: reset pulse, 2-word config
// write, periodic CONVST and NUM_CH-word readout. FRAME_TIMESTAMP_EN adds o_frame_ts.
module ads_par_adc_driver
    import ads_drv_pkg::*;
#(
    parameter int                DATA_W       = 16,
    parameter int                NUM_CH       = 8,
    parameter int                CONV_PERIOD  = 500,
    parameter int                RD_LOW       = 2,
    parameter int                RD_HIGH      = 2,
    parameter int                WR_LOW       = 2,
    parameter int                RST_CYC      = 8,
    parameter logic [DATA_W-1:0] CFG_HI       = DATA_W'(CFG_HI_DEF),
    parameter logic [DATA_W-1:0] CFG_LO       = DATA_W'(CFG_LO_DEF),
    parameter int                BUSY_TIMEOUT = 1024
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_enable,
    output logic [(NUM_CH+1)/2-1:0]   o_adc_convst,
    output logic                      o_adc_cs_n,
    output logic                      o_adc_rd_n,
    output logic                      o_adc_wr_n,
    output logic                      o_adc_hw_sw,
    output logic                      o_adc_par_ser,
    output logic                      o_adc_rst,
    output logic                      o_adc_stby_n,
    input  logic                      i_adc_busy,
    input  logic [DATA_W-1:0]         i_db,
    output logic [DATA_W-1:0]         o_db,
    output logic                      o_db_oe,
    output logic                      o_cfg_done,
    output logic [DATA_W-1:0]         o_sample_data,
    output logic [2:0]                o_sample_ch,
    output logic                      o_sample_valid,
    output logic                      o_sample_last,
    output logic                      o_frame_overrun,
    output logic                      o_busy_err
`ifdef FRAME_TIMESTAMP_EN
    ,
    output logic [31:0]               o_frame_ts
`endif
);
    localparam int CNT_W = 16;
    localparam int PER_W = $clog2(CONV_PERIOD + 1);
    localparam int CV_W  = (NUM_CH + 1) / 2;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_word, w_word_nxt;
    logic [2:0]         r_ch, w_ch_nxt;
    logic [PER_W-1:0]   r_per;
    logic               r_cfg_done, r_valid, r_last, r_ovr, r_berr;
    logic [DATA_W-1:0]  r_data;
    logic [2:0]         r_sch;
    logic               w_cap, w_done, w_berr, w_exp, w_busy_s, w_tout;

    ads_busy_sync #(.BUSY_TIMEOUT(BUSY_TIMEOUT)) u_busy (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_busy    (i_adc_busy),
        .i_wait    (r_state == S_BUSY_HI || r_state == S_BUSY_LO),
        .i_target  (r_state == S_BUSY_HI),
        .o_busy_s  (w_busy_s),
        .o_timeout (w_tout)
    );

    assign w_exp = r_cfg_done && (r_per == PER_W'(CONV_PERIOD - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_ARST;
            r_cnt      <= '0;
            r_word     <= 1'b0;
            r_ch       <= '0;
            r_per      <= '0;
            r_cfg_done <= 1'b0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_ovr      <= 1'b0;
            r_berr     <= 1'b0;
            r_data     <= '0;
            r_sch      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_word     <= w_word_nxt;
            r_ch       <= w_ch_nxt;
            r_per      <= (!r_cfg_done || w_exp) ? '0 : r_per + 1'b1;
            r_cfg_done <= r_cfg_done | w_done;
            r_valid    <= w_cap;
            r_last     <= w_cap && (r_ch == 3'(NUM_CH - 1));
            r_ovr      <= w_exp && (r_state != S_IDLE);
            r_berr     <= w_berr;
            if (w_cap) begin
                r_data <= i_db;
                r_sch  <= r_ch;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_word_nxt  = r_word;
        w_ch_nxt    = r_ch;
        w_cap       = 1'b0;
        w_done      = 1'b0;
        w_berr      = 1'b0;
        case (r_state)
            S_ARST: if (r_cnt == CNT_W'(RST_CYC - 1)) begin
                w_state_nxt = S_CFG;
                w_cnt_nxt   = '0;
            end
            // Each config word: 1 setup cycle, WR_LOW low, WR_LOW high.
            S_CFG: if (r_cnt == CNT_W'(2 * WR_LOW)) begin
                w_cnt_nxt  = '0;
                w_word_nxt = 1'b1;
                if (r_word) begin
                    w_state_nxt = S_IDLE;
                    w_done      = 1'b1;
                end
            end
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_exp && i_enable) w_state_nxt = S_CONV;
            end
            S_CONV: if (r_cnt == CNT_W'(1)) begin
                w_state_nxt = S_BUSY_HI;
                w_cnt_nxt   = '0;
            end
            S_BUSY_HI: begin
                w_cnt_nxt = '0;
                if (w_busy_s) w_state_nxt = S_BUSY_LO;
                else if (w_tout) begin
                    w_state_nxt = S_IDLE;
                    w_berr      = 1'b1;
                end
            end
            S_BUSY_LO: begin
                w_cnt_nxt = '0;
                w_ch_nxt  = '0;
                if (!w_busy_s) w_state_nxt = S_RD_L;
                else if (w_tout) begin
                    w_state_nxt = S_IDLE;
                    w_berr      = 1'b1;
                end
            end
            S_RD_L: if (r_cnt == CNT_W'(RD_LOW - 1)) begin
                w_state_nxt = S_RD_H;
                w_cnt_nxt   = '0;
                w_cap       = 1'b1;
            end
            S_RD_H: if (r_cnt == CNT_W'(RD_HIGH - 1)) begin
                w_cnt_nxt = '0;
                if (r_ch == 3'(NUM_CH - 1)) w_state_nxt = S_IDLE;
                else begin
                    w_ch_nxt    = r_ch + 1'b1;
                    w_state_nxt = S_RD_L;
                end
            end
            default: w_state_nxt = S_ARST;
        endcase
    end

    assign o_adc_convst    = {CV_W{r_state == S_CONV}};
    assign o_adc_cs_n      = !(r_state == S_CFG || r_state == S_RD_L || r_state == S_RD_H);
    assign o_adc_rd_n      = r_state != S_RD_L;
    assign o_adc_wr_n      = !(r_state == S_CFG && r_cnt != '0 && r_cnt <= CNT_W'(WR_LOW));
    assign o_adc_hw_sw     = 1'b0;
    assign o_adc_par_ser   = 1'b0;
    assign o_adc_rst       = r_state == S_ARST;
    assign o_adc_stby_n    = 1'b1;
    assign o_db_oe         = r_state == S_CFG;
    assign o_db            = (r_state == S_CFG) ? (r_word ? CFG_LO : CFG_HI) : '0;
    assign o_cfg_done      = r_cfg_done;
    assign o_sample_data   = r_data;
    assign o_sample_ch     = r_sch;
    assign o_sample_valid  = r_valid;
    assign o_sample_last   = r_last;
    assign o_frame_overrun = r_ovr;
    assign o_busy_err      = r_berr;

`ifdef FRAME_TIMESTAMP_EN
    logic [31:0] r_ts, r_frame_ts;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ts       <= '0;
            r_frame_ts <= '0;
        end else begin
            r_ts <= r_ts + 1'b1;
            if (r_state == S_CONV && r_cnt == '0) r_frame_ts <= r_ts;
        end
    end
    assign o_frame_ts = r_frame_ts;
`endif

    a_no_oe_during_rd: assert property (@(posedge i_clk) !(o_db_oe && !o_adc_rd_n));
endmodule

// File: tb/tb_ads_par_adc_driver.sv
// tb_ads_par_adc_driver: directed bench with a behavioural ADC pin model; DUT0 uses
// default timing, DUT1 a 40-cycle period so frames overrun the conversion slot.
module tb_ads_par_adc_driver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b1;
    logic [1:0] no_busy = 2'b00;
    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [3:0]  conv0, conv1;
    logic        cs_n0, rd_n0, wr_n0, hw0, ps0, arst0, stby0, oe0, done0, val0, last0, ovr0, berr0;
    logic        cs_n1, rd_n1, wr_n1, hw1, ps1, arst1, stby1, oe1, done1, val1, last1, ovr1, berr1;
    logic [15:0] dbo0, data0, dbo1, data1;
    logic [2:0]  ch0, ch1;
    logic [1:0]  adc_busy, adc_cv, adc_rdn;
    logic [15:0] adc_db [2];
`ifdef FRAME_TIMESTAMP_EN
    logic [31:0] fts0, fts1;
`endif

    assign adc_cv  = {conv1[0], conv0[0]};
    assign adc_rdn = {rd_n1, rd_n0};

    ads_par_adc_driver dut0 (
        .i_clk(clk), .i_rst(rst), .i_enable(en), .o_adc_convst(conv0), .o_adc_cs_n(cs_n0),
        .o_adc_rd_n(rd_n0), .o_adc_wr_n(wr_n0), .o_adc_hw_sw(hw0), .o_adc_par_ser(ps0),
        .o_adc_rst(arst0), .o_adc_stby_n(stby0), .i_adc_busy(adc_busy[0]), .i_db(adc_db[0]),
        .o_db(dbo0), .o_db_oe(oe0), .o_cfg_done(done0), .o_sample_data(data0),
        .o_sample_ch(ch0), .o_sample_valid(val0), .o_sample_last(last0),
        .o_frame_overrun(ovr0), .o_busy_err(berr0)
`ifdef FRAME_TIMESTAMP_EN
        , .o_frame_ts(fts0)
`endif
    );

    ads_par_adc_driver #(.CONV_PERIOD(40)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_enable(en), .o_adc_convst(conv1), .o_adc_cs_n(cs_n1),
        .o_adc_rd_n(rd_n1), .o_adc_wr_n(wr_n1), .o_adc_hw_sw(hw1), .o_adc_par_ser(ps1),
        .o_adc_rst(arst1), .o_adc_stby_n(stby1), .i_adc_busy(adc_busy[1]), .i_db(adc_db[1]),
        .o_db(dbo1), .o_db_oe(oe1), .o_cfg_done(done1), .o_sample_data(data1),
        .o_sample_ch(ch1), .o_sample_valid(val1), .o_sample_last(last1),
        .o_frame_overrun(ovr1), .o_busy_err(berr1)
`ifdef FRAME_TIMESTAMP_EN
        , .o_frame_ts(fts1)
`endif
    );

    // ADC pins: BUSY high 40 cycles after CONVST rises; each RD pulse advances to the next channel.
    for (genvar g = 0; g < 2; g++) begin : g_adc
        logic cv_q = 1'b0;
        logic rd_q = 1'b1;
        int left = 0;
        int idx = 0;
        always @(posedge clk) begin
            cv_q <= adc_cv[g];
            rd_q <= adc_rdn[g];
            if (adc_cv[g] && !cv_q) begin
                idx  <= 0;
                left <= no_busy[g] ? 0 : 40;
            end else begin
                if (left != 0) left <= left - 1;
                if (adc_rdn[g] && !rd_q) idx <= idx + 1;
            end
        end
        assign adc_busy[g] = left != 0;
        assign adc_db[g]   = 16'hA000 + 16'(idx);
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Expected stream: within every frame the k-th sample is channel k carrying A000+k.
    int exp0 = 0, smp0 = 0, lasts0 = 0, convs0 = 0, ovrs0 = 0, berrs0 = 0;
    int conv_cyc0 = 0, conv_prev0 = 0, berr_cyc0 = 0;
    logic cq0 = 1'b0;
    logic [15:0] ldata0 = '0;
    logic [2:0] lch0 = '0;
    logic [31:0] ts_cur = '0, ts_prev = '0;
    always @(negedge clk) begin
        chk("static_pins0", {hw0, ps0, stby0, oe0 & ~rd_n0, (conv0 != 4'h0) && (conv0 != 4'hF)}, 5'b00100);
        if (rst) exp0 = 0;
        else begin
            if (val0) begin
`ifdef FRAME_TIMESTAMP_EN
                if (exp0 == 0) begin
                    ts_prev = ts_cur;
                    ts_cur  = fts0;
                end else chk("ts_stable", fts0, ts_cur);
`endif
                chk("smp_data0", data0, 16'hA000 + exp0);
                chk("smp_ch0", ch0, exp0);
                chk("smp_last0", last0, exp0 == 7);
                ldata0 = data0;
                lch0   = ch0;
                if (last0) lasts0++;
                smp0++;
                exp0 = (exp0 + 1) % 8;
            end
            if (conv0[0] && !cq0) begin
                chk("frame_whole0", exp0, 0);
                conv_prev0 = conv_cyc0;
                conv_cyc0  = cyc;
                convs0++;
            end
            if (ovr0) ovrs0++;
            if (berr0) begin
                berr_cyc0 = cyc;
                berrs0++;
            end
        end
        cq0 = conv0[0];
    end

    int exp1 = 0, convs1 = 0, ovrs1 = 0, conv_cyc1 = -1;
    logic cq1 = 1'b0;
    always @(negedge clk) begin
        chk("static_pins1", {hw1, ps1, stby1, oe1 & ~rd_n1}, 4'b0010);
        if (rst) begin
            exp1 = 0;
            conv_cyc1 = -1;
        end else begin
            if (val1) begin
                chk("smp_data1", data1, 16'hA000 + exp1);
                chk("smp_ch1", ch1, exp1);
                chk("smp_last1", last1, exp1 == 7);
                exp1 = (exp1 + 1) % 8;
            end
            if (conv1[0] && !cq1) begin
                chk("frame_whole1", exp1, 0);
                if (conv_cyc1 >= 0) chk("slot_align1", (cyc - conv_cyc1) % 40, 0);
                conv_cyc1 = cyc;
                convs1++;
            end
            if (ovr1) ovrs1++;
        end
        cq1 = conv1[0];
    end

    function automatic int ev(input int w);
        return (w == 0) ? convs0 : (w == 1) ? lasts0 : berrs0;
    endfunction

    task automatic wait_ev(input int w, input string nm, input int budget);
        int n = 0;
        int c = ev(w);
        while (ev(w) == c && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, ev(w) != c, 1);
    endtask

    task automatic cfg_seq();
        int n;
        logic [15:0] prev, want;
        n = 0;
        prev = '0;
        @(negedge clk);
        while (arst0 && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("adc_rst_cycles", n, 8);
        for (int k = 0; k < 2; k++) begin
            want = (k == 0) ? 16'h1500 : 16'h0000;
            n = 0;
            while (wr_n0 && n < 20) begin
                prev = dbo0;
                n++;
                @(negedge clk);
            end
            chk("cfg_setup", prev, want);
            chk("cfg_bus", {oe0, cs_n0}, 2'b10);
            n = 0;
            while (!wr_n0 && n < 20) begin
                chk("cfg_word", dbo0, want);
                n++;
                @(negedge clk);
            end
            chk("wr_low_cycles", n, 2);
            chk("cfg_hold", dbo0, want);
        end
        n = 0;
        while (!done0 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("cfg_done", {done0, oe0, cs_n0}, 3'b101);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        int n, s, o, b, l;
        repeat (3) @(negedge clk);
        chk("rst_strobes", {arst0, cs_n0, rd_n0, wr_n0, oe0, done0}, 6'b111100);
        chk("rst_convst", conv0, 0);
        chk("rst_db_o", dbo0, 0);
        chk("rst_sample", {val0, last0, data0, ch0}, 0);
        chk("rst_pulses", {ovr0, berr0}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        cfg_seq();

        wait_ev(0, "conv_a", 700);
        s = smp0;
        o = ovrs0;
        wait_ev(0, "conv_b", 600);
        chk("conv_spacing_ab", conv_cyc0 - conv_prev0, 500);
        chk("frame_smp_a", smp0 - s, 8);
        s = smp0;
        wait_ev(0, "conv_c", 600);
        chk("conv_spacing_bc", conv_cyc0 - conv_prev0, 500);
        chk("frame_smp_b", smp0 - s, 8);
        wait_ev(1, "frame_c_end", 200);
        chk("no_overrun", ovrs0 - o, 0);
        chk("last_word", ldata0, 16'hA007);
        chk("last_ch", lch0, 7);
`ifdef FRAME_TIMESTAMP_EN
        chk("ts_delta", ts_cur - ts_prev, 500);
`endif

        no_busy[0] = 1'b1;
        o = ovrs0;
        b = berrs0;
        wait_ev(0, "conv_nobusy", 600);
        wait_ev(2, "busy_err", 1200);
        chk("berr_latency", berr_cyc0 - conv_cyc0, 1026);
        no_busy[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("berr_pulse", berrs0 - b, 1);
        wait_ev(0, "conv_after_err", 1200);
        chk("skip_spacing", conv_cyc0 - conv_prev0, 1500);
        chk("overruns", ovrs0 - o, 2);
        s = smp0;
        wait_ev(1, "frame_after_err", 200);
        chk("recovered_frame", smp0 - s, 8);

        l = lasts0;
        n = 0;
        while (!(exp0 == 3 && !rd_n0) && n < 700) begin
            @(negedge clk);
            n++;
        end
        chk("reach_4th_read", n < 700, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_pins", {rd_n0, oe0, arst0, cs_n0, wr_n0, done0}, 6'b101110);
        @(posedge clk);
        #1 rst = 1'b0;
        cfg_seq();
        chk("no_partial_last", lasts0 - l, 0);
        wait_ev(0, "conv_after_rst", 700);
        s = smp0;
        wait_ev(1, "frame_after_rst", 200);
        chk("frame_after_rst_smp", smp0 - s, 8);

        chk("ovr1_seen", ovrs1 > 0, 1);
        chk("frames1", convs1 >= 10, 1);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
